// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instructions into a held IR and resolves the next PC on retire.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        bneq,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] retired_count
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, cnt_q, cnt_d;
  logic [31:0] next_pc, br_tgt, j_tgt, jr_tgt;
  logic        br_taken;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign jr_tgt   = rs_data & 32'hFFFF_FFFC;
  assign br_taken = branch & (zero ^ bneq);
  assign next_pc  = jr ? jr_tgt : (jump | jal) ? j_tgt : br_taken ? br_tgt : pc_plus4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ready) begin
        state_d = EXEC;
        ir_d    = imem_rdata;
      end
      EXEC:  if (retire) begin
        state_d = FETCH;
        pc_d    = next_pc;
        cnt_d   = cnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign imem_req      = state_q == FETCH;
  assign instr_valid   = state_q == EXEC;
  assign imem_addr     = pc_q;
  assign instr         = ir_q;
  assign opcode        = ir_q[31:26];
  assign func          = ir_q[5:0];
  assign retired_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch/retire traffic scored against a PC-level reference model.
module tb_instr_fetch_unit;
  logic        clk = 0, rst_n = 0;
  logic        imem_req, imem_ready = 0, instr_valid, retire = 0;
  logic        branch = 0, bneq = 0, jump = 0, jal = 0, jr = 0, zero = 0;
  logic [31:0] imem_addr, imem_rdata = 0, instr, pc_plus4, rs_data = 0, retired_count;
  logic [5:0]  opcode, func;
  int          tests = 0, fails = 0;
  logic [31:0] mpc = 0, mcnt = 0;
  logic [31:0] addr_q[$], ir_q[$], p4_q[$];
  logic        prev_v = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .opcode(opcode), .func(func), .pc_plus4(pc_plus4),
    .retire(retire), .branch(branch), .bneq(bneq), .jump(jump), .jal(jal), .jr(jr),
    .zero(zero), .rs_data(rs_data), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the next fetch address derived directly from the ISA redirect rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
      input logic b, input logic bn, input logic j, input logic jl, input logic r,
      input logic z, input logic [31:0] rs);
    logic [31:0] p4;
    p4 = pc + 4;
    if (r) return rs - (rs % 4);
    if (j || jl) return (p4 & 32'hF000_0000) + (ir & 32'h03FF_FFFF) * 4;
    if (b && (z != bn)) return p4 + 32'($signed(ir[15:0])) * 4;
    return p4;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) prev_v = 0;
    else begin
      if (imem_req && imem_ready) begin
        if (addr_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
        else chk("fetch_addr", imem_addr, addr_q.pop_front());
      end
      if (instr_valid && !prev_v) begin
        if (ir_q.size() == 0) chk("unexpected_valid", instr, 32'hDEAD_BEEF);
        else begin
          logic [31:0] e;
          e = ir_q.pop_front();
          chk("instr", instr, e);
          chk("opcode", {26'b0, opcode}, e >> 26);
          chk("func", {26'b0, func}, e % 64);
          chk("pc_plus4", pc_plus4, p4_q.pop_front());
        end
      end
      prev_v = instr_valid;
    end
  end

  task automatic run_instr(input logic [31:0] ir, input int waits, input int hold,
      input logic b, input logic bn, input logic j, input logic jl, input logic r,
      input logic z, input logic [31:0] rs);
    int n = 0;
    while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
    if (!imem_req) chk("req_timeout", {31'b0, imem_req}, 32'd1);
    for (int w = 0; w < waits; w++) begin
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
      chk("wait_addr", imem_addr, mpc);
      imem_rdata = $urandom;
      retire = 1'($urandom);
      @(posedge clk); #1;
    end
    retire = 0;
    imem_rdata = ir; imem_ready = 1;
    addr_q.push_back(mpc); ir_q.push_back(ir); p4_q.push_back(mpc + 4);
    @(posedge clk); #1;
    imem_rdata = $urandom;
    for (int h = 0; h < hold; h++) begin
      imem_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("ir_stable", instr, ir);
    end
    imem_ready = 0;
    {branch, bneq, jump, jal, jr, zero, rs_data} = {b, bn, j, jl, r, z, rs};
    retire = 1;
    mpc = model_next(mpc, ir, b, bn, j, jl, r, z, rs);
    mcnt++;
    @(posedge clk); #1;
    retire = 0;
    {branch, bneq, jump, jal, jr, zero} = 6'($urandom);
    chk("retired_count", retired_count, mcnt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_count"}, retired_count, 32'd0);
  endtask

  task automatic rand_instr();
    logic r, j;
    r = ($urandom % 6) == 0;
    j = ($urandom % 5) == 0;
    run_instr($urandom, $urandom % 3, $urandom % 3, 1'($urandom), 1'($urandom),
              j, j & 1'($urandom), r, 1'($urandom),
              ($urandom % 8 == 0) ? 32'hFFFF_FFFC | 32'($urandom % 4) : $urandom);
  endtask

  initial begin
    #3 chk_reset_outputs("reset_t0");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset_held");
    @(negedge clk); rst_n = 1; retire = 1;
    #1 chk("idle_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    retire = 0;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("idle_retire_ignored", retired_count, 32'd0);
    for (int i = 0; i < 3; i++) run_instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq_count", retired_count, 32'd3);
    chk("seq_addr", imem_addr, 32'hC);
    run_instr($urandom, 3, 0, 0, 0, 0, 0, 1, 0, 32'h13);
    chk("jr_align", imem_addr, 32'h10);
    run_instr(32'h1000FFFE, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    chk("beq_taken", imem_addr, 32'hC);
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10);
    run_instr(32'h1000FFFE, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    chk("bne_not_taken", imem_addr, 32'h14);
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4000_0000);
    run_instr(32'h0C00_0010, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    chk("jal_target", imem_addr, 32'h4000_0040);
    run_instr(32'h1000FFFE, 0, 0, 1, 0, 1, 0, 1, 1, 32'h0000_1233);
    chk("jr_priority", imem_addr, 32'h0000_1230);
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pc_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 150; i++) rand_instr();
    // Abandon an instruction mid-EXEC with an asynchronous reset between edges.
    while (!imem_req) begin @(posedge clk); #1; end
    imem_rdata = $urandom; imem_ready = 1;
    addr_q.push_back(mpc); ir_q.push_back(imem_rdata); p4_q.push_back(mpc + 4);
    @(posedge clk); #1; imem_ready = 0;
    @(negedge clk); #2;
    retire = 1; rst_n = 0;
    #1 chk_reset_outputs("async_reset");
    chk("async_pc_plus4", pc_plus4, 32'd4);
    repeat (2) @(posedge clk);
    addr_q.delete(); ir_q.delete(); p4_q.delete();
    mpc = 0; mcnt = 0;
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    retire = 0;
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_count", retired_count, 32'd0);
    for (int i = 0; i < 50; i++) rand_instr();
    repeat (3) @(posedge clk);
    chk("queues_drained", addr_q.size() + ir_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
